alu_181_seq: RTL and testbench



---
 rtl/alu_181_seq_if.sv | 30 +++
 rtl/alu_181_seq.sv | 136 +++++++++++++
 tb/tb_alu_181_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_181_seq_if.sv
// Operand/result handshake bundle for alu_181_seq.
// The master side issues operands and consumes results; the slave side is the ALU.
interface alu_181_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             m;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             c_out;
    logic             ovf;
    logic             a_eq_b;
    logic             busy;

    modport master (
        output in_valid, a, b, s, m, c_in, out_ready,
        input  in_ready, out_valid, f, c_out, ovf, a_eq_b, busy
    );

    modport slave (
        input  in_valid, a, b, s, m, c_in, out_ready,
        output in_ready, out_valid, f, c_out, ovf, a_eq_b, busy
    );
endinterface

// File: rtl/alu_181_seq.sv
// Sequential 74181-style ALU: computes one 4-bit slice per clock, LSB first,
// with a registered carry between slices and valid/ready on both sides.
module alu_181_seq #(
    parameter int unsigned WIDTH = 8
) (
    input logic         clk,
    input logic         rst,
    alu_181_seq_if.slave bus
);
    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, f_q, f_d;
    logic [3:0]       s_q, s_d;
    logic             m_q, m_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             eq_q, eq_d;

    // Current slice operands and results
    logic [3:0] sa, sb, x, y, lf, lo;
    logic [4:0] sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            k_q     <= '0;
            carry_q <= 1'b0;
            f_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            m_q     <= m_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            f_q     <= f_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            eq_q    <= eq_d;
        end
    end

    always_comb begin
        sa = a_q[4*k_q +: 4];
        sb = b_q[4*k_q +: 4];
        x  = '0;
        y  = '0;
        lf = '0;
        case (s_q)
            4'd0:  begin x = sa;        y = 4'h0;      lf = ~sa;        end
            4'd1:  begin x = sa | sb;   y = 4'h0;      lf = ~(sa | sb); end
            4'd2:  begin x = sa | ~sb;  y = 4'h0;      lf = ~sa & sb;   end
            4'd3:  begin x = 4'h0;      y = 4'hf;      lf = 4'h0;       end
            4'd4:  begin x = sa;        y = sa & ~sb;  lf = ~(sa & sb); end
            4'd5:  begin x = sa | sb;   y = sa & ~sb;  lf = ~sb;        end
            4'd6:  begin x = sa;        y = ~sb;       lf = sa ^ sb;    end
            4'd7:  begin x = sa & ~sb;  y = 4'hf;      lf = sa & ~sb;   end
            4'd8:  begin x = sa;        y = sa & sb;   lf = ~sa | sb;   end
            4'd9:  begin x = sa;        y = sb;        lf = ~(sa ^ sb); end
            4'd10: begin x = sa | ~sb;  y = sa & sb;   lf = sb;         end
            4'd11: begin x = sa & sb;   y = 4'hf;      lf = sa & sb;    end
            4'd12: begin x = sa;        y = sa;        lf = 4'hf;       end
            4'd13: begin x = sa | sb;   y = sa;        lf = sa | ~sb;   end
            4'd14: begin x = sa | ~sb;  y = sa;        lf = sa | sb;    end
            default: begin x = sa;      y = 4'hf;      lf = sa;         end
        endcase
        sum = {1'b0, x} + {1'b0, y} + {4'b0, carry_q};
        // lo[3] is the carry into the slice MSB, needed for signed overflow
        lo  = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b0, carry_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        m_d     = m_q;
        k_d     = k_q;
        carry_d = carry_q;
        f_d     = f_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        eq_d    = eq_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    s_d     = bus.s;
                    m_d     = bus.m;
                    k_d     = '0;
                    carry_d = bus.m ? 1'b0 : bus.c_in;
                    f_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                f_d[4*k_q +: 4] = m_q ? lf : sum[3:0];
                carry_d         = m_q ? 1'b0 : sum[4];
                k_d             = k_q + 1'b1;
                if (k_q == KW'(NSLICE - 1)) begin
                    c_out_d = m_q ? 1'b0 : sum[4];
                    ovf_d   = m_q ? 1'b0 : (lo[3] ^ sum[4]);
                    eq_d    = &f_d;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q == StRun) || (state_q == StDone);
    assign bus.f         = f_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
    assign bus.a_eq_b    = eq_q;
endmodule

// File: tb/tb_alu_181_seq.sv
// Self-checking bench for alu_181_seq: directed cases plus random operations
// against a whole-word arithmetic reference model, at WIDTH=8 and WIDTH=16.
module tb_alu_181_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_181_seq_if #(.WIDTH(8))  bus8 ();
    alu_181_seq_if #(.WIDTH(16)) bus16 ();

    alu_181_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    alu_181_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Whole-word reference: F = X + Y + cin, flags from plain integer arithmetic
    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] s, input logic m, input logic cin,
                                  output logic [31:0] ef, output logic [31:0] ec,
                                  output logic [31:0] eo, output logic [31:0] ee);
        int unsigned mask, av, bv, nb, x, y, sum, hm, c_msb;
        mask = (32'd1 << w) - 1;
        hm   = (32'd1 << (w - 1)) - 1;
        av   = {16'd0, a} & mask;
        bv   = {16'd0, b} & mask;
        nb   = ~bv & mask;
        ec   = 0;
        eo   = 0;
        if (m) begin
            case (s)
                0: ef = ~av;           1: ef = ~(av | bv);
                2: ef = ~av & bv;      3: ef = 0;
                4: ef = ~(av & bv);    5: ef = nb;
                6: ef = av ^ bv;       7: ef = av & nb;
                8: ef = ~av | bv;      9: ef = ~(av ^ bv);
                10: ef = bv;           11: ef = av & bv;
                12: ef = mask;         13: ef = av | nb;
                14: ef = av | bv;      default: ef = av;
            endcase
            ef = ef & mask;
        end else begin
            case (s)
                0: begin x = av; y = 0; end
                1: begin x = av | bv; y = 0; end
                2: begin x = av | nb; y = 0; end
                3: begin x = 0; y = mask; end
                4: begin x = av; y = av & nb; end
                5: begin x = av | bv; y = av & nb; end
                6: begin x = av; y = nb; end
                7: begin x = av & nb; y = mask; end
                8: begin x = av; y = av & bv; end
                9: begin x = av; y = bv; end
                10: begin x = av | nb; y = av & bv; end
                11: begin x = av & bv; y = mask; end
                12: begin x = av; y = av; end
                13: begin x = av | bv; y = av; end
                14: begin x = av | nb; y = av; end
                default: begin x = av; y = mask; end
            endcase
            sum   = x + y + {31'd0, cin};
            ef    = sum & mask;
            ec    = (sum >> w) & 1;
            c_msb = (((x & hm) + (y & hm) + {31'd0, cin}) >> (w - 1)) & 1;
            eo    = c_msb ^ ec;
        end
        ee = {31'd0, ef == mask};
    endfunction

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] s, input logic m, input logic cin, input bit pop);
        logic [31:0] ef, ec, eo, ee;
        int edges = 0;
        check({tag, ".ready"}, {31'd0, bus8.in_ready}, 1);
        bus8.a = a; bus8.b = b; bus8.s = s; bus8.m = m; bus8.c_in = cin;
        bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        while (!bus8.out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, ".latency"}, edges, 2);
        model(8, {8'd0, a}, {8'd0, b}, s, m, cin, ef, ec, eo, ee);
        check({tag, ".f"}, {24'd0, bus8.f}, ef);
        check({tag, ".c_out"}, {31'd0, bus8.c_out}, ec);
        check({tag, ".ovf"}, {31'd0, bus8.ovf}, eo);
        check({tag, ".a_eq_b"}, {31'd0, bus8.a_eq_b}, ee);
        if (pop) begin
            bus8.out_ready = 1'b1;
            @(posedge clk); #1;
            bus8.out_ready = 1'b0;
        end
    endtask

    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] s, input logic m, input logic cin);
        logic [31:0] ef, ec, eo, ee;
        int edges = 0;
        bus16.a = a; bus16.b = b; bus16.s = s; bus16.m = m; bus16.c_in = cin;
        bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        while (!bus16.out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, ".latency"}, edges, 4);
        model(16, a, b, s, m, cin, ef, ec, eo, ee);
        check({tag, ".f"}, {16'd0, bus16.f}, ef);
        check({tag, ".c_out"}, {31'd0, bus16.c_out}, ec);
        check({tag, ".ovf"}, {31'd0, bus16.ovf}, eo);
        check({tag, ".a_eq_b"}, {31'd0, bus16.a_eq_b}, ee);
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
    endtask

    logic [7:0]  hold_f;
    logic [31:0] ef, ec, eo, ee;
    bit          stale;

    initial begin
        bus8.in_valid = 0;  bus8.out_ready = 0;  bus8.a = 0;  bus8.b = 0;
        bus8.s = 0;  bus8.m = 0;  bus8.c_in = 0;
        bus16.in_valid = 0; bus16.out_ready = 0; bus16.a = 0; bus16.b = 0;
        bus16.s = 0; bus16.m = 0; bus16.c_in = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("reset.in_ready", {31'd0, bus8.in_ready}, 1);
        check("reset.out_valid", {31'd0, bus8.out_valid}, 0);
        check("reset.busy", {31'd0, bus8.busy}, 0);
        check("reset.f", {24'd0, bus8.f}, 0);

        // Reset mid-RUN: accept, then hold rst for two edges
        bus8.a = 8'h4C; bus8.b = 8'h37; bus8.s = 4'd9; bus8.m = 0; bus8.c_in = 0;
        bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("midrun.in_ready", {31'd0, bus8.in_ready}, 1);
        check("midrun.out_valid", {31'd0, bus8.out_valid}, 0);
        check("midrun.busy", {31'd0, bus8.busy}, 0);
        check("midrun.f", {24'd0, bus8.f}, 0);
        check("midrun.flags", {29'd0, bus8.c_out, bus8.ovf, bus8.a_eq_b}, 0);
        stale = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus8.out_valid) stale = 1;
        end
        check("midrun.no_stale", {31'd0, stale}, 0);

        op8("add_ovf", 8'h4C, 8'h37, 4'd9, 1'b0, 1'b0, 1);
        check("add_ovf.f_lit", {24'd0, bus8.f}, 32'h83);
        op8("ripple", 8'hFF, 8'h00, 4'd9, 1'b0, 1'b1, 1);
        op8("cmp_eq", 8'h5A, 8'h5A, 4'd6, 1'b0, 1'b0, 1);
        check("cmp_eq.lit", {23'd0, bus8.a_eq_b, bus8.f}, 32'h1FF);
        op8("cmp_cin", 8'h5A, 8'h5A, 4'd6, 1'b0, 1'b1, 1);
        for (int i = 0; i < 16; i++) op8($sformatf("logic_s%0d", i), 8'h04, 8'h03, 4'(i), 1'b1, 1'b0, 1);
        op8("xor_f0_3c", 8'hF0, 8'h3C, 4'd6, 1'b1, 1'b0, 1);
        check("xor_f0_3c.lit", {24'd0, bus8.f}, 32'hCC);

        // Backpressure: result stays put and nothing is captured
        op8("bp", 8'h12, 8'h34, 4'd9, 1'b0, 1'b0, 0);
        hold_f = bus8.f;
        for (int i = 0; i < 5; i++) begin
            bus8.in_valid = i[0];
            bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.s = 4'($urandom);
            @(posedge clk); #1;
            check("bp.f_hold", {24'd0, bus8.f}, {24'd0, hold_f});
            check("bp.in_ready", {31'd0, bus8.in_ready}, 0);
            check("bp.out_valid", {31'd0, bus8.out_valid}, 1);
        end
        // Pop with in_valid high: no same-cycle start
        bus8.a = 8'h10; bus8.b = 8'h20; bus8.s = 4'd9; bus8.m = 0; bus8.c_in = 0;
        bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        check("pop.in_ready", {31'd0, bus8.in_ready}, 1);
        check("pop.busy", {31'd0, bus8.busy}, 0);
        check("pop.f_kept", {24'd0, bus8.f}, {24'd0, hold_f});
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        check("next.busy", {31'd0, bus8.busy}, 1);
        repeat (2) @(posedge clk);
        #1 check("next.out_valid", {31'd0, bus8.out_valid}, 1);
        check("next.f", {24'd0, bus8.f}, 32'h30);
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;

        for (int i = 0; i < 40; i++)
            op8($sformatf("rand8_%0d", i), 8'($urandom), 8'($urandom), 4'($urandom),
                1'($urandom), 1'($urandom), 1);

        op16("ripple16", 16'hFFFF, 16'h0000, 4'd9, 1'b0, 1'b1);
        check("ripple16.lit", {15'd0, bus16.c_out, bus16.f}, 32'h10000);
        for (int i = 0; i < 20; i++)
            op16($sformatf("rand16_%0d", i), 16'($urandom), 16'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
